sad_search_ctrl: RTL and testbench
==================================

Name: sad_search_ctrl

Overview:
- Sequences motion-search candidates through the 5-stage pipelined 256-pixel SAD adder tree and selects the minimum-SAD candidate.
- Sits between the candidate/absolute-difference generator (upstream) and the mode-decision logic (downstream).
- The adder tree has no valid signal, so this block tracks in-flight candidates with a shadow valid/index pipeline. It then compares each emerging sum against the running minimum.

Parameters:
- NUM_CAND, 16, number of candidates per search (1..256).
- SUM_LATENCY, 5, clock edges from ad captured to matching sum output.
- IDX_W, 8, width of candidate index; must satisfy NUM_CAND <= 2**IDX_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse to begin a search; ignored while busy.
- busy  output  1  high from the cycle after an accepted start until done.
- cand_valid  output  1  candidate cand_idx is requested this cycle.
- cand_idx  output  IDX_W  index of candidate whose ad must be driven into the adder this cycle.
- cand_ready  input  1  generator has ad for cand_idx on the adder input this cycle.
- sum_in  input  16  SAD from the adder tree output.
- best_sad  output  16  minimum SAD of last completed search.
- best_idx  output  IDX_W  index achieving best_sad.
- done  output  1  one-cycle pulse; best_sad/best_idx valid from this cycle until the next done.

Behaviour:
- Reset: rst_n sampled low at a clock edge clears all state.
  - Outputs: busy=0, cand_valid=0, cand_idx=0, best_sad=16'hFFFF, best_idx=0, done=0.
  - Shadow pipeline is cleared to all invalid.
- Reset mid-search aborts the search with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 -> ISSUE; next_idx=0, run_min=16'hFFFF, run_idx=0.
  - ISSUE: cand_valid=1, cand_idx=next_idx.
    - A candidate is issued when cand_valid && cand_ready.
    - On issue, next_idx increments.
    - Issue of index NUM_CAND-1 -> DRAIN.
    - cand_ready=0 stalls: next_idx holds, a bubble enters the shadow pipe.
  - DRAIN: cand_valid=0; stays until the shadow pipe holds no valid entries, then -> DONE.
  - DONE: for one cycle, done=1; best_sad<=run_min and best_idx<=run_idx (registered, visible with done); -> IDLE.
- Shadow pipe:
  - SUM_LATENCY-deep shift register of {valid, idx}, shifted every cycle regardless of state.
  - Head is loaded with {issue, cand_idx}.
  - When the tail is valid, sum_in belongs to the tail idx.
  - Net timing: candidate issued in cycle t is compared in cycle t+SUM_LATENCY.
- Compare: tail valid and sum_in < run_min (strict) -> run_min<=sum_in, run_idx<=tail idx.
  - Ties keep the earlier (lower) index.
  - sum_in=16'hFFFF never displaces the initial minimum. run_idx then stays 0, which is intended.
- start during ISSUE/DRAIN/DONE is ignored. start in the same cycle as done is ignored. start in IDLE is accepted.
- busy=1 in ISSUE, DRAIN and DONE.
- Minimum search duration with no stalls: NUM_CAND + SUM_LATENCY + 1 cycles from start to done.
- The bubble-versus-candidate rule guarantees sums from bubbles are never compared.

Optional Feature:
- Macro SAD_EARLY_EXIT_EN adds input port exit_thresh [15:0] and output port early_exit [0:0].
- With the macro defined:
  - In ISSUE, a compared sum_in < exit_thresh forces -> DRAIN. No further candidates are issued; in-flight candidates are still compared.
  - early_exit is registered with done and held until the next done. It is 1 if the search terminated early, else 0.
  - exit_thresh=0 never triggers.
- Without the macro: neither port exists and all NUM_CAND candidates are always evaluated.

Test Plan:
- No stalls, NUM_CAND=16, sum_in per idx = 1000-10*idx -> done exactly 22 cycles after start; best_sad=850, best_idx=15; cand_idx runs 0..15 on consecutive cycles.
- Ties: SADs all 500 except idx 3 and idx 9 = 200 -> best_sad=200, best_idx=3.
- Stalls: cand_ready toggles 1,0,1,0 -> every index issued exactly once. Garbage bubble sums of 0 are injected on the sum path and do not affect the result (best per the programmed idx values). done is delayed by the stall count.
- Reset mid-search: rst_n low for 1 cycle during DRAIN -> no done; busy=0 next cycle; best_sad=16'hFFFF. A new start then completes normally.
- start held high continuously -> exactly one search per IDLE visit; start pulses while busy are ignored, verified by a cand_idx count of 16 per done.
- With SAD_EARLY_EXIT_EN, exit_thresh=100, idx 4 SAD=50, others 300 -> no issue after idx 4 compare; done with best_idx=4, best_sad=50, early_exit=1.

Source files
------------

// File: rtl/sad_search_if.sv
// Handshake bundle between the SAD search controller, the candidate/AD generator and mode decision.
// SAD_EARLY_EXIT_EN adds the early-exit threshold and status signals.
interface sad_search_if #(
   parameter int IDX_W = 8
);
   logic             start;
   logic             busy;
   logic             cand_valid;
   logic [IDX_W-1:0] cand_idx;
   logic             cand_ready;
   logic [15:0]      sum_in;
   logic [15:0]      best_sad;
   logic [IDX_W-1:0] best_idx;
   logic             done;
`ifdef SAD_EARLY_EXIT_EN
   logic [15:0]      exit_thresh;
   logic             early_exit;

   modport master (
      output start, cand_ready, sum_in, exit_thresh,
      input  busy, cand_valid, cand_idx, best_sad, best_idx, done, early_exit
   );
   modport slave (
      input  start, cand_ready, sum_in, exit_thresh,
      output busy, cand_valid, cand_idx, best_sad, best_idx, done, early_exit
   );
`else
   modport master (
      output start, cand_ready, sum_in,
      input  busy, cand_valid, cand_idx, best_sad, best_idx, done
   );
   modport slave (
      input  start, cand_ready, sum_in,
      output busy, cand_valid, cand_idx, best_sad, best_idx, done
   );
`endif
endinterface

// File: rtl/sad_search_ctrl.sv
// Issues motion-search candidates into the SAD adder tree and tracks the minimum-SAD candidate.
// Optional SAD_EARLY_EXIT_EN stops issuing once a compared SAD falls below exit_thresh.
module sad_search_ctrl #(
   parameter int NUM_CAND    = 16,
   parameter int SUM_LATENCY = 5,
   parameter int IDX_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   sad_search_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] next_idx;
   logic [15:0]      run_min, run_min_nxt;
   logic [IDX_W-1:0] run_idx, run_idx_nxt;
   logic [15:0]      best_sad;
   logic [IDX_W-1:0] best_idx;

   // Shadow of the adder tree: stage 0 is the head, stage SUM_LATENCY-1 lines up with sum_in.
   logic [SUM_LATENCY-1:0] vld_p;
   logic [IDX_W-1:0]       idx_p [SUM_LATENCY];

   logic             cand_valid;
   logic [IDX_W-1:0] cand_idx;
   logic             issue;
   logic             cmp_hit;
   logic             pipe_drained;
   logic             exit_hit;
   logic             accept;

   assign accept  = (state == IDLE) && bus.start;
   assign cmp_hit = vld_p[SUM_LATENCY-1] && (bus.sum_in < run_min);
   assign cand_idx = (state == ISSUE) ? next_idx : '0;

`ifdef SAD_EARLY_EXIT_EN
   logic exit_seen;
   logic early_exit;
   assign exit_hit = (state == ISSUE) && vld_p[SUM_LATENCY-1] && (bus.sum_in < bus.exit_thresh);
   assign bus.early_exit = early_exit;
`else
   assign exit_hit = 1'b0;
`endif

   // Only the tail may still be valid: it is compared this cycle, so the pipe is empty afterwards.
   always_comb begin
      pipe_drained = 1'b1;
      for (int i = 0; i < SUM_LATENCY - 1; i++) begin
         if (vld_p[i]) pipe_drained = 1'b0;
      end
   end

   always_comb begin
      run_min_nxt = run_min;
      run_idx_nxt = run_idx;
      if (cmp_hit) begin
         run_min_nxt = bus.sum_in;
         run_idx_nxt = idx_p[SUM_LATENCY-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cand_valid = 1'b0;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (exit_hit) begin
               state_nxt = DRAIN;
            end else begin
               cand_valid = 1'b1;
               issue      = bus.cand_ready;
               if (issue && (next_idx == LAST_IDX)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pipe_drained) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         next_idx <= '0;
         run_min  <= 16'hFFFF;
         run_idx  <= '0;
         best_sad <= 16'hFFFF;
         best_idx <= '0;
         vld_p    <= '0;
         for (int i = 0; i < SUM_LATENCY; i++) idx_p[i] <= '0;
      end else begin
         vld_p[0] <= issue;
         idx_p[0] <= cand_idx;
         for (int i = 1; i < SUM_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
            idx_p[i] <= idx_p[i-1];
         end
         if (accept) begin
            next_idx <= '0;
            run_min  <= 16'hFFFF;
            run_idx  <= '0;
         end else begin
            if (issue) next_idx <= next_idx + IDX_W'(1);
            run_min <= run_min_nxt;
            run_idx <= run_idx_nxt;
         end
         // Result includes the tail compare happening on the same edge.
         if ((state == DRAIN) && pipe_drained) begin
            best_sad <= run_min_nxt;
            best_idx <= run_idx_nxt;
         end
      end
   end

`ifdef SAD_EARLY_EXIT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exit_seen  <= 1'b0;
         early_exit <= 1'b0;
      end else begin
         if (accept)        exit_seen <= 1'b0;
         else if (exit_hit) exit_seen <= 1'b1;
         if ((state == DRAIN) && pipe_drained) early_exit <= exit_seen;
      end
   end
`endif

   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.cand_valid = cand_valid;
   assign bus.cand_idx   = cand_idx;
   assign bus.best_sad   = best_sad;
   assign bus.best_idx   = best_idx;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl: models the 5-deep adder tree and checks search results.
// Early-exit scenario is compiled in when SAD_EARLY_EXIT_EN is defined.
module tb_sad_search_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sad_search_if #(.IDX_W(8)) bus ();

   sad_search_ctrl #(.NUM_CAND(16), .SUM_LATENCY(5), .IDX_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] sad_tab [16];
   logic [15:0] bubble_sum = 16'h0000;
   logic [15:0] pipe [5] = '{default: 16'h0000};
   int cyc_cnt  = 0;
   int done_cnt = 0;
   int iss_cnt  = 0;
   int bad_idx  = 0;
   int hits    [16] = '{default: 0};
   int iss_cyc [16] = '{default: 0};

   // Adder-tree model: AD captured on an issue edge emerges on sum_in five edges later.
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus.cand_valid === 1'b1 && bus.cand_ready === 1'b1) begin
         iss_cnt <= iss_cnt + 1;
         if (bus.cand_idx < 8'd16) begin
            hits[bus.cand_idx[3:0]]    <= hits[bus.cand_idx[3:0]] + 1;
            iss_cyc[bus.cand_idx[3:0]] <= cyc_cnt;
            pipe[0] <= sad_tab[bus.cand_idx[3:0]];
         end else begin
            bad_idx <= bad_idx + 1;
            pipe[0] <= bubble_sum;
         end
      end else begin
         pipe[0] <= bubble_sum;
      end
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
   end

   assign bus.sum_in = pipe[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_and_wait(input bit toggle, output int cyc);
      bus.start = 1'b1;
      bus.cand_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (toggle) bus.cand_ready = cyc[0];
      end
      check("done_seen", {31'd0, bus.done}, 32'd1);
   endtask

   int cyc, iss0, done0, m;
   int hits0 [16];
   bit ok;

   initial begin
      bus.start = 1'b0;
      bus.cand_ready = 1'b1;
`ifdef SAD_EARLY_EXIT_EN
      bus.exit_thresh = 16'd0;
`endif
      for (int i = 0; i < 16; i++) sad_tab[i] = 16'(1000 - 10 * i);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",       {31'd0, bus.busy},       32'd0);
      check("rst_cand_valid", {31'd0, bus.cand_valid}, 32'd0);
      check("rst_cand_idx",   {24'd0, bus.cand_idx},   32'd0);
      check("rst_best_sad",   {16'd0, bus.best_sad},   32'hFFFF);
      check("rst_best_idx",   {24'd0, bus.best_idx},   32'd0);
      check("rst_done",       {31'd0, bus.done},       32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Descending SADs, no stalls
      iss0 = iss_cnt;
      start_and_wait(1'b0, cyc);
      check("t1_latency", cyc, 22);
      check("t1_best_sad", {16'd0, bus.best_sad}, 32'd850);
      check("t1_best_idx", {24'd0, bus.best_idx}, 32'd15);
      check("t1_issues", iss_cnt - iss0, 16);
      ok = 1'b1;
      for (int k = 1; k < 16; k++) if (iss_cyc[k] != iss_cyc[0] + k) ok = 1'b0;
      check("t1_consecutive_idx", {31'd0, ok}, 32'd1);
      check("t1_bad_idx", bad_idx, 0);
`ifdef SAD_EARLY_EXIT_EN
      check("t1_early_exit", {31'd0, bus.early_exit}, 32'd0);
`endif
      @(posedge clk); #1;

      // Ties keep the lower index
      for (int i = 0; i < 16; i++) sad_tab[i] = 16'd500;
      sad_tab[3] = 16'd200;
      sad_tab[9] = 16'd200;
      start_and_wait(1'b0, cyc);
      check("t2_latency", cyc, 22);
      check("t2_best_sad", {16'd0, bus.best_sad}, 32'd200);
      check("t2_best_idx", {24'd0, bus.best_idx}, 32'd3);
      @(posedge clk); #1;

      // Alternating stalls with zero-valued bubble sums
      for (int i = 0; i < 16; i++) sad_tab[i] = 16'd400;
      sad_tab[6] = 16'd123;
      bubble_sum = 16'd0;
      hits0 = hits;
      iss0 = iss_cnt;
      start_and_wait(1'b1, cyc);
      check("t3_latency", cyc, 37);
      check("t3_best_sad", {16'd0, bus.best_sad}, 32'd123);
      check("t3_best_idx", {24'd0, bus.best_idx}, 32'd6);
      check("t3_issues", iss_cnt - iss0, 16);
      ok = 1'b1;
      for (int k = 0; k < 16; k++) if (hits[k] - hits0[k] != 1) ok = 1'b0;
      check("t3_each_once", {31'd0, ok}, 32'd1);
      bus.cand_ready = 1'b1;
      @(posedge clk); #1;

      // Reset during DRAIN aborts the search
      for (int i = 0; i < 16; i++) sad_tab[i] = 16'(1000 - 10 * i);
      done0 = done_cnt;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (18) begin @(posedge clk); #1; end
      check("t4_in_drain_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t4_busy", {31'd0, bus.busy}, 32'd0);
      check("t4_done", {31'd0, bus.done}, 32'd0);
      check("t4_best_sad", {16'd0, bus.best_sad}, 32'hFFFF);
      rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      check("t4_no_done", done_cnt - done0, 0);
      start_and_wait(1'b0, cyc);
      check("t4_restart_latency", cyc, 22);
      check("t4_restart_best_sad", {16'd0, bus.best_sad}, 32'd850);
      check("t4_restart_best_idx", {24'd0, bus.best_idx}, 32'd15);
      @(posedge clk); #1;

      // start held high: one search per IDLE visit
      iss0 = iss_cnt;
      bus.start = 1'b1;
      m = 0;
      while (bus.done !== 1'b1 && m < 100) begin @(posedge clk); #1; m++; end
      check("t5_first_latency", m, 22);
      check("t5_first_issues", iss_cnt - iss0, 16);
      iss0 = iss_cnt;
      @(posedge clk); #1;
      m = 1;
      while (bus.done !== 1'b1 && m < 100) begin @(posedge clk); #1; m++; end
      check("t5_second_interval", m, 23);
      check("t5_second_issues", iss_cnt - iss0, 16);
      bus.start = 1'b0;
      iss0 = iss_cnt;
      repeat (3) begin @(posedge clk); #1; end
      check("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_no_third", iss_cnt - iss0, 0);

`ifdef SAD_EARLY_EXIT_EN
      // Early exit on a SAD below threshold
      for (int i = 0; i < 16; i++) sad_tab[i] = 16'd300;
      sad_tab[4] = 16'd50;
      bus.exit_thresh = 16'd100;
      iss0 = iss_cnt;
      start_and_wait(1'b0, cyc);
      check("t6_latency", cyc, 15);
      check("t6_best_sad", {16'd0, bus.best_sad}, 32'd50);
      check("t6_best_idx", {24'd0, bus.best_idx}, 32'd4);
      check("t6_early_exit", {31'd0, bus.early_exit}, 32'd1);
      check("t6_issues", iss_cnt - iss0, 9);
      bus.exit_thresh = 16'd0;
      @(posedge clk); #1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
